active_list: RTL

- In-order commit buffer for the renamed pipeline: a circular list of 2^FREE_LIST_WIDTH entries, allocated at rename and marked complete by the writeback stage (the consumer of the MEM/WB register outputs).
- Retires completed entries strictly in program order, one per cycle.
- On retire, publishes the committed virtual-to-physical mapping and returns the superseded physical register to the free list.

---
 rtl/active_list_if.sv | 38 +++
 rtl/active_list.sv | 129 ++++++++++++
 2 files changed

// File: rtl/active_list_if.sv
// Rename/writeback/commit bundle of the active list: allocation request,
// completion report, and the registered retire/free results.
interface active_list_if #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic                       alloc_wb_reg;
  logic [REG_ADDR_WIDTH-1:0]  alloc_virtual_addr;
  logic [REG_ADDR_WIDTH-1:0]  alloc_physical_addr;
  logic [REG_ADDR_WIDTH-1:0]  alloc_old_physical_addr;
  logic [FREE_LIST_WIDTH-1:0] alloc_index;

  logic                       complete_valid;
  logic [FREE_LIST_WIDTH-1:0] complete_index;

  logic                       retire_valid;
  logic                       retire_wb_reg;
  logic [REG_ADDR_WIDTH-1:0]  retire_virtual_addr;
  logic [REG_ADDR_WIDTH-1:0]  retire_physical_addr;
  logic                       free_valid;
  logic [REG_ADDR_WIDTH-1:0]  free_physical_addr;

  modport master (
    output alloc_valid, alloc_wb_reg, alloc_virtual_addr, alloc_physical_addr,
           alloc_old_physical_addr, complete_valid, complete_index,
    input  alloc_ready, alloc_index, retire_valid, retire_wb_reg,
           retire_virtual_addr, retire_physical_addr, free_valid, free_physical_addr
  );

  modport slave (
    input  alloc_valid, alloc_wb_reg, alloc_virtual_addr, alloc_physical_addr,
           alloc_old_physical_addr, complete_valid, complete_index,
    output alloc_ready, alloc_index, retire_valid, retire_wb_reg,
           retire_virtual_addr, retire_physical_addr, free_valid, free_physical_addr
  );
endinterface

// File: rtl/active_list.sv
// In-order commit buffer: entries allocated at rename, marked done at writeback,
// retired one per cycle from the head with mapping publish and old-register free.
module active_list #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     stall,
  active_list_if.slave             bus,
  output logic [FREE_LIST_WIDTH:0] count,
  output logic                     empty
);
  localparam int DEPTH = 1 << FREE_LIST_WIDTH;

  logic [FREE_LIST_WIDTH-1:0] head_reg, tail_reg;
  logic [FREE_LIST_WIDTH:0]   count_reg, count_next;
  logic [DEPTH-1:0]           valid_reg, valid_next;
  logic [DEPTH-1:0]           done_reg, done_next;

  logic                       wb_mem   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0]  virt_mem [DEPTH];
  logic [REG_ADDR_WIDTH-1:0]  phys_mem [DEPTH];
  logic [REG_ADDR_WIDTH-1:0]  old_mem  [DEPTH];

  logic                       retire_valid_reg, retire_wb_reg_reg, free_valid_reg;
  logic [REG_ADDR_WIDTH-1:0]  retire_virt_reg, retire_phys_reg, free_phys_reg;

  logic alloc_ready, alloc_fire, retire_fire;

  assign alloc_ready = (count_reg != (FREE_LIST_WIDTH + 1)'(DEPTH));
  assign alloc_fire  = bus.alloc_valid && alloc_ready;
  assign retire_fire = !stall && valid_reg[head_reg] && done_reg[head_reg];

  // Flush overrides everything; allocation beats a same-cycle completion of the tail.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic alloc_hit, retire_hit, complete_hit;
      assign alloc_hit    = alloc_fire  && (tail_reg == FREE_LIST_WIDTH'(gi));
      assign retire_hit   = retire_fire && (head_reg == FREE_LIST_WIDTH'(gi));
      assign complete_hit = bus.complete_valid && valid_reg[gi] &&
                            (bus.complete_index == FREE_LIST_WIDTH'(gi));
      assign valid_next[gi] = flush      ? 1'b0 :
                              alloc_hit  ? 1'b1 :
                              retire_hit ? 1'b0 : valid_reg[gi];
      assign done_next[gi]  = flush        ? 1'b0 :
                              alloc_hit    ? 1'b0 :
                              retire_hit   ? 1'b0 :
                              complete_hit ? 1'b1 : done_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (alloc_fire && !retire_fire)
      count_next = count_reg + 1'b1;
    else if (!alloc_fire && retire_fire)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
      done_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
      count_reg <= count_next;
      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (alloc_fire)  tail_reg <= tail_reg + 1'b1;
        if (retire_fire) head_reg <= head_reg + 1'b1;
      end
    end
  end

  // Payload storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (alloc_fire && !flush) begin
      wb_mem[tail_reg]   <= bus.alloc_wb_reg;
      virt_mem[tail_reg] <= bus.alloc_virtual_addr;
      phys_mem[tail_reg] <= bus.alloc_physical_addr;
      old_mem[tail_reg]  <= bus.alloc_old_physical_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid_reg  <= 1'b0;
      retire_wb_reg_reg <= 1'b0;
      retire_virt_reg   <= '0;
      retire_phys_reg   <= '0;
      free_valid_reg    <= 1'b0;
      free_phys_reg     <= '0;
    end else if (flush) begin
      retire_valid_reg <= 1'b0;
      free_valid_reg   <= 1'b0;
    end else if (retire_fire) begin
      retire_valid_reg  <= 1'b1;
      retire_wb_reg_reg <= wb_mem[head_reg];
      retire_virt_reg   <= virt_mem[head_reg];
      retire_phys_reg   <= phys_mem[head_reg];
      free_valid_reg    <= wb_mem[head_reg];
      free_phys_reg     <= wb_mem[head_reg] ? old_mem[head_reg] : '0;
    end else begin
      retire_valid_reg <= 1'b0;
      free_valid_reg   <= 1'b0;
    end
  end

  assign bus.alloc_ready          = alloc_ready;
  assign bus.alloc_index          = tail_reg;
  assign bus.retire_valid         = retire_valid_reg;
  assign bus.retire_wb_reg        = retire_wb_reg_reg;
  assign bus.retire_virtual_addr  = retire_virt_reg;
  assign bus.retire_physical_addr = retire_phys_reg;
  assign bus.free_valid           = free_valid_reg;
  assign bus.free_physical_addr   = free_phys_reg;
  assign count                    = count_reg;
  assign empty                    = (count_reg == '0);
endmodule
